// File: rtl/change_dispenser.sv
// change_dispenser: turns a change amount (cents) into a greedy sequence of
// coin ejects (dollar, quarter, dime, nickel) over a valid/ack handshake.
// Optional coin inventory is enabled by defining CHANGE_DISPENSER_INVENTORY_EN.
module change_dispenser #(
   parameter int AMT_W       = 9,
   parameter int MAX_AMOUNT  = 500,
   parameter int ACK_TIMEOUT = 255,
   parameter int STOCK_W     = 8,
   parameter int INIT_STOCK  = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   output logic             eject_valid,
   output logic [1:0]       eject_coin,
   input  logic             eject_ack,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             fault,
   output logic             short,
   output logic [AMT_W-1:0] remaining,
   input  logic             refill,
   output logic [3:0]       stock_empty
);

`ifdef CHANGE_DISPENSER_INVENTORY_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SELECT, S_EJECT, S_DONE} state_t;

   state_t        state, next;
   logic [TW-1:0] tcnt;
   logic          bad_req, timeout, ack_hit, pick_ok;
   logic [1:0]    pick;
   logic [3:0]    avail, elig;

   function automatic logic [AMT_W-1:0] coin_val(input logic [1:0] c);
      case (c)
         2'd0:    coin_val = AMT_W'(5);
         2'd1:    coin_val = AMT_W'(10);
         2'd2:    coin_val = AMT_W'(25);
         default: coin_val = AMT_W'(100);
      endcase
   endfunction

   assign bad_req = (remaining > AMT_W'(MAX_AMOUNT)) || ((remaining % AMT_W'(5)) != '0);
   assign timeout = (tcnt == TW'(ACK_TIMEOUT - 1));
   assign ack_hit = (state == S_EJECT) && eject_ack;

   // Greedy choice: highest-coded eligible coin wins (codes are ordered by value)
   always_comb begin
      elig    = '0;
      pick_ok = 1'b0;
      pick    = 2'd0;
      for (int c = 0; c < 4; c++) begin
         elig[c] = avail[c] && (coin_val(2'(c)) <= remaining);
         if (elig[c]) begin
            pick_ok = 1'b1;
            pick    = 2'(c);
         end
      end
   end

   // State register; reset drops eject_valid immediately since it decodes state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      next        = state;
      busy        = (state != S_IDLE);
      done        = (state == S_DONE);
      eject_valid = (state == S_EJECT);
      case (state)
         S_IDLE:   if (start) next = S_CHECK;
         S_CHECK:  next = bad_req ? S_DONE : S_SELECT;
         S_SELECT: next = (remaining == '0 || !pick_ok) ? S_DONE : S_EJECT;
         S_EJECT: begin
            if (eject_ack)    next = S_SELECT;
            else if (timeout) next = S_DONE;
         end
         S_DONE:   next = S_IDLE;
         default:  next = S_IDLE;
      endcase
   end

   // Datapath: owed amount, selected coin, ack timer and sticky status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining  <= '0;
         eject_coin <= 2'd0;
         tcnt       <= '0;
         err        <= 1'b0;
         fault      <= 1'b0;
         short      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               remaining <= amount;
               err       <= 1'b0;
               fault     <= 1'b0;
               short     <= 1'b0;
            end
            S_CHECK: if (bad_req) err <= 1'b1;
            S_SELECT: begin
               tcnt <= '0;
               if (remaining != '0) begin
                  if (pick_ok) eject_coin <= pick;
                  else         short      <= INV_EN;
               end
            end
            S_EJECT: begin
               if (eject_ack) begin
                  remaining <= remaining - coin_val(eject_coin);
                  tcnt      <= '0;
               end else if (timeout) begin
                  fault <= 1'b1;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CHANGE_DISPENSER_INVENTORY_EN
   logic [3:0][STOCK_W-1:0] stock;

   // Per-coin stock: refill only when not dispensing, decrement on each drop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stock <= {4{STOCK_W'(INIT_STOCK)}};
      end else if (refill && (state == S_IDLE || state == S_DONE)) begin
         stock <= {4{STOCK_W'(INIT_STOCK)}};
      end else if (ack_hit) begin
         stock[eject_coin] <= stock[eject_coin] - STOCK_W'(1);
      end
   end

   // Empty flags double as the SELECT eligibility mask
   always_comb begin
      stock_empty = '0;
      for (int c = 0; c < 4; c++) stock_empty[c] = (stock[c] == '0);
   end
   assign avail = ~stock_empty;
`else
   logic [STOCK_W-1:0] unused_stock;
   logic               unused_ack_hit;

   // Infinite stock: every coin always eligible, refill has no effect
   assign stock_empty    = '0;
   assign avail          = '1;
   assign unused_stock   = STOCK_W'(INIT_STOCK) ^ {STOCK_W{refill}};
   assign unused_ack_hit = ack_hit;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy coin model predicts every
// eject and the final status; a monitor pops and compares on DUT events.
module tb_change_dispenser;
   localparam int AMT_W   = 9;
   localparam int ACK_TO  = 20;
   localparam int INIT_ST = 3;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
   localparam bit INV = 1'b1;
`else
   localparam bit INV = 1'b0;
`endif

   typedef struct {
      bit         is_done;
      logic [1:0] coin;
      logic [8:0] rem;
      bit         err, fault, short_f;
      logic [3:0] empty;
   } exp_t;

   logic             clk, rst_n, start, eject_ack, refill;
   logic [AMT_W-1:0] amount;
   logic             eject_valid, busy, done, err, fault, short;
   logic [1:0]       eject_coin;
   logic [AMT_W-1:0] remaining;
   logic [3:0]       stock_empty;

   int   checks = 0, errors = 0;
   exp_t sbq[$];
   bit   ack_mode = 0;
   int   stock_m[4];
   int   vrun = 0, lastrun = 0;
   int   VAL[4] = '{5, 10, 25, 100};

   change_dispenser #(.AMT_W(AMT_W), .MAX_AMOUNT(500), .ACK_TIMEOUT(ACK_TO),
                      .STOCK_W(8), .INIT_STOCK(INIT_ST)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .amount(amount),
      .eject_valid(eject_valid), .eject_coin(eject_coin), .eject_ack(eject_ack),
      .busy(busy), .done(done), .err(err), .fault(fault), .short(short),
      .remaining(remaining), .refill(refill), .stock_empty(stock_empty));

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, expv);
      end
   endtask

   // Mechanism model: ack after a random 0..4 cycle delay, plus stray acks while idle
   initial begin
      int vcnt, tgt;
      vcnt = 0; tgt = 0;
      eject_ack = 0;
      forever begin
         @(posedge clk); #1;
         if (ack_mode) eject_ack = 0;
         else if (!eject_valid) begin
            vcnt = 0;
            tgt = $urandom_range(0, 4);
            eject_ack = ($urandom_range(0, 7) == 0);
         end else begin
            eject_ack = (vcnt == tgt);
            vcnt++;
         end
      end
   end

   // Monitor: compare each coin handshake and each done against the queue
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         vrun = 0; lastrun = 0;
      end else begin
         if (eject_valid) vrun++;
         else if (vrun != 0) begin lastrun = vrun; vrun = 0; end
         if (eject_valid && eject_ack) begin
            if (sbq.size() == 0) chk("coin_unexpected", 1, 0);
            else begin
               e = sbq.pop_front();
               chk("coin_vs_done", {31'd0, e.is_done}, 0);
               chk("coin", eject_coin, e.coin);
            end
         end
         if (done) begin
            if (sbq.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               e = sbq.pop_front();
               chk("done_vs_coin", {31'd0, e.is_done}, 1);
               chk("remaining", remaining, e.rem);
               chk("err", err, e.err);
               chk("fault", fault, e.fault);
               chk("short", short, e.short_f);
               chk("stock_empty", stock_empty, e.empty);
               chk("busy_at_done", busy, 1);
               if (e.fault) chk("timeout_len", lastrun, ACK_TO);
            end
         end
      end
   end

   // Issue one request; the model predicts coins greedily from the rules
   task automatic req(input int amt, input bit noack, input bit rf);
      exp_t e, c;
      int rem, pk, cyc;
      ack_mode = noack;
      if (rf && INV) foreach (stock_m[i]) stock_m[i] = INIT_ST;
      e = '{default: 0};
      e.is_done = 1;
      if (amt > 500 || amt % 5 != 0) begin
         e.err = 1; e.rem = 9'(amt);
      end else begin
         rem = amt;
         while (rem > 0) begin
            pk = -1;
            for (int k = 0; k < 4; k++)
               if (VAL[k] <= rem && (!INV || stock_m[k] > 0)) pk = k;
            if (pk < 0) begin e.short_f = 1; break; end
            if (noack) begin e.fault = 1; break; end
            c = '{default: 0};
            c.coin = 2'(pk);
            sbq.push_back(c);
            rem -= VAL[pk];
            if (INV) stock_m[pk]--;
         end
         e.rem = 9'(rem);
      end
      for (int k = 0; k < 4; k++) e.empty[k] = INV && (stock_m[k] == 0);
      sbq.push_back(e);

      start = 1; amount = 9'(amt); refill = rf;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         start = 0; refill = 0; cyc++;
         if (cyc == 1) begin
            chk("busy_after_start", busy, 1);
            refill = ($urandom_range(0, 3) == 0);  // must be ignored while busy
         end
      end while (!done && cyc < 2000);
      refill = 0;
      chk("done_seen", done, 1);
      if (amt == 0) chk("zero_latency", cyc, 3);
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      int cyc, a;
      rst_n = 0; start = 0; amount = 0; refill = 0;
      foreach (stock_m[i]) stock_m[i] = INIT_ST;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", eject_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_flags", {err, fault, short}, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_empty", stock_empty, 0);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;

      req(190, 0, 0);
      req(0, 0, 0);
      req(7, 0, 0);
      req(505, 0, 0);
      req(500, 0, 0);
      req(25, 1, 0);
      req(500, 0, 1);
      req(5, 0, 0);

      // Reset asserted while a coin request is outstanding
      ack_mode = 1;
      start = 1; amount = 9'd100; refill = 1;
      @(posedge clk); #1;
      start = 0; refill = 0; cyc = 0;
      while (!eject_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
      chk("rst_reach_eject", eject_valid, 1);
      @(posedge clk); #1;
      rst_n = 0; #1;
      chk("midrst_valid", eject_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_remaining", remaining, 0);
      chk("midrst_done", done, 0);
      foreach (stock_m[i]) stock_m[i] = INIT_ST;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      ack_mode = 0;
      @(posedge clk); #1;

      for (int n = 0; n < 120; n++) begin
         if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 511);
         else a = 5 * $urandom_range(0, 100);
         req(a, $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0);
      end

      repeat (3) @(posedge clk);
      chk("queue_drained", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
